// File: rtl/rtl_settings_pkg.sv
// Shared settings for the memory test slice.
// Holds the address width used across the codebase, the default geometry
// of the memory-side transmitter, and its FSM state type.
// No ports (package).
package rtl_settings_pkg;

  localparam int ADDR_W           = 32;
  localparam int MEM_DATA_W       = 128;
  localparam int MEM_BURST_LEN    = 4;
  localparam int MEM_MAX_RD_WORDS = 64;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    WRITE_S = 2'd1,
    READ_S  = 2'd2
  } mem_trans_state_t;

endpackage

// File: rtl/mem_trans_block.sv
// mem_trans_block: memory-side transmitter.
// Accepts one command per valid/ready handshake (read/write, start word
// address) and issues one Avalon-MM burst of BURST_LEN beats for it. Writes
// carry a pattern derived from the seed captured at accept; reads are only
// issued here, and returning readdatavalid pulses are counted so that
// trans_busy_o stays high until every requested read word has come back.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   trans_valid_i/ready_o   command handshake from control_block
//   trans_type_i            1 = read, 0 = write
//   trans_addr_i            burst start word address
//   pattern_i               write data seed, sampled at accept
//   trans_busy_o            burst in progress or read words outstanding
//   mem_*                   Avalon-MM master port to the memory under test
//   rd_unexp_o              sticky: readdatavalid with nothing outstanding
//   stall_cnt_o             waitrequest stall cycles of the current test
//
// Optional feature macro: MEM_TRANS_STALL_CNT_EN enables the stall counter;
// without it stall_cnt_o is tied to zero.
module mem_trans_block
  import rtl_settings_pkg::*;
#(
  parameter int DATA_W       = MEM_DATA_W,
  parameter int BURST_LEN    = MEM_BURST_LEN,
  parameter int MAX_RD_WORDS = MEM_MAX_RD_WORDS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trans_valid_i,
  input  logic              trans_type_i,
  input  logic [ADDR_W-1:0] trans_addr_i,
  output logic              trans_ready_o,
  output logic              trans_busy_o,
  input  logic [31:0]       pattern_i,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [DATA_W-1:0] mem_writedata_o,
  output logic [7:0]        mem_burstcount_o,
  input  logic              mem_waitrequest_i,
  input  logic              mem_readdatavalid_i,
  output logic              rd_unexp_o,
  output logic [31:0]       stall_cnt_o
);

  localparam int RD_W = $clog2(MAX_RD_WORDS + 1);
  localparam logic [7:0]      LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [RD_W-1:0] BURST_INC = RD_W'(BURST_LEN);
  localparam logic [RD_W:0]   RD_LIMIT  = (RD_W + 1)'(MAX_RD_WORDS);

  mem_trans_state_t  state_q, state_d;
  logic [7:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       seed_q, seed_d;
  logic [RD_W-1:0]   rd_pend_q, rd_pend_d;
  logic              rd_unexp_q, rd_unexp_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              read_taken;
  logic [RD_W:0]     rd_room_sum;

  // All Avalon outputs come straight from registers, so they stay stable
  // under waitrequest and fall asynchronously with reset.
  assign mem_write_o      = (state_q == WRITE_S);
  assign mem_read_o       = (state_q == READ_S);
  assign mem_address_o    = (state_q != IDLE_S) ? addr_q : '0;
  assign mem_writedata_o  = mem_write_o ? ({(DATA_W/32){seed_q}} ^ DATA_W'(beat_q)) : '0;
  assign mem_burstcount_o = 8'(BURST_LEN);
  assign trans_busy_o     = busy_q;
  assign rd_unexp_o       = rd_unexp_q;

  // A read is only accepted when its whole burst still fits in the
  // outstanding-word budget; the sum is one bit wider to avoid wrap.
  assign rd_room_sum   = {1'b0, rd_pend_q} + {1'b0, BURST_INC};
  assign trans_ready_o = (state_q == IDLE_S) && (!trans_type_i || (rd_room_sum <= RD_LIMIT));
  assign accept        = trans_valid_i && trans_ready_o;
  assign read_taken    = mem_read_o && !mem_waitrequest_i;

  // Next-state logic: command capture in idle, beat stepping for writes,
  // single-cycle (plus waitrequest) request phase for reads.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    case (state_q)
      IDLE_S: begin
        if (accept) begin
          state_d = trans_type_i ? READ_S : WRITE_S;
          addr_d  = trans_addr_i;
          seed_d  = pattern_i;
          beat_d  = '0;
        end
      end
      WRITE_S: begin
        if (!mem_waitrequest_i) begin
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE_S;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      READ_S: begin
        if (!mem_waitrequest_i) begin
          state_d = IDLE_S;
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  // Outstanding read words: a pulse with nothing pending is flagged rather
  // than decremented, so the counter never wraps below zero.
  always_comb begin
    rd_pend_d  = rd_pend_q;
    rd_unexp_d = rd_unexp_q;
    if (mem_readdatavalid_i) begin
      if (rd_pend_q == '0) begin
        rd_unexp_d = 1'b1;
      end else begin
        rd_pend_d = rd_pend_q - 1'b1;
      end
    end
    if (read_taken) begin
      rd_pend_d = rd_pend_d + BURST_INC;
    end
  end

  // Busy looks ahead at next state so it rises the cycle after accept and
  // falls the cycle after the last write beat or last read word.
  always_comb begin
    busy_d = (state_d != IDLE_S) || (rd_pend_d != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE_S;
      beat_q     <= '0;
      addr_q     <= '0;
      seed_q     <= '0;
      rd_pend_q  <= '0;
      rd_unexp_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      seed_q     <= seed_d;
      rd_pend_q  <= rd_pend_d;
      rd_unexp_q <= rd_unexp_d;
      busy_q     <= busy_d;
    end
  end

`ifdef MEM_TRANS_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // The counter restarts on the first command of a test (nothing busy,
  // nothing outstanding) and saturates instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (accept && (rd_pend_q == '0) && !busy_q) begin
      stall_cnt_d = '0;
    end else if ((mem_read_o || mem_write_o) && mem_waitrequest_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_trans_block.sv
// Self-checking bench for mem_trans_block: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a transaction-level model of the transmitter.
module tb_mem_trans_block;
  import rtl_settings_pkg::*;

  localparam int BL    = 4;
  localparam int MAXRD = 64;
  localparam int DW    = 128;
  localparam int AW    = ADDR_W;

  logic          clk_i;
  logic          rst_i;
  logic          trans_valid_i;
  logic          trans_type_i;
  logic [AW-1:0] trans_addr_i;
  logic          trans_ready_o;
  logic          trans_busy_o;
  logic [31:0]   pattern_i;
  logic [AW-1:0] mem_address_o;
  logic          mem_read_o;
  logic          mem_write_o;
  logic [DW-1:0] mem_writedata_o;
  logic [7:0]    mem_burstcount_o;
  logic          mem_waitrequest_i;
  logic          mem_readdatavalid_i;
  logic          rd_unexp_o;
  logic [31:0]   stall_cnt_o;

  mem_trans_block dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .trans_valid_i       (trans_valid_i),
    .trans_type_i        (trans_type_i),
    .trans_addr_i        (trans_addr_i),
    .trans_ready_o       (trans_ready_o),
    .trans_busy_o        (trans_busy_o),
    .pattern_i           (pattern_i),
    .mem_address_o       (mem_address_o),
    .mem_read_o          (mem_read_o),
    .mem_write_o         (mem_write_o),
    .mem_writedata_o     (mem_writedata_o),
    .mem_burstcount_o    (mem_burstcount_o),
    .mem_waitrequest_i   (mem_waitrequest_i),
    .mem_readdatavalid_i (mem_readdatavalid_i),
    .rd_unexp_o          (rd_unexp_o),
    .stall_cnt_o         (stall_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  // Transaction-level model: one burst in flight at most, plus a word count
  // of reads requested but not yet returned.
  bit            mActive = 0;
  bit            mIsRead = 0;
  logic [AW-1:0] mAddr   = '0;
  logic [31:0]   mSeed   = '0;
  int            mBeat   = 0;
  int            mPend   = 0;
  bit            mUnexp  = 0;
  bit            mBusy   = 0;
  logic [31:0]   mStall  = '0;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelReady(input bit isRead);
    return !mActive && (!isRead || (mPend + BL <= MAXRD));
  endfunction

  function automatic logic [DW-1:0] beatData(input logic [31:0] seed, input int k);
    logic [DW-1:0] d;
    d = {(DW/32){seed}};
    return d ^ DW'(k);
  endfunction

  task automatic modelReset();
    mActive = 0; mIsRead = 0; mAddr = '0; mSeed = '0; mBeat = 0;
    mPend = 0; mUnexp = 0; mBusy = 0; mStall = '0;
  endtask

  task automatic modelStep();
    bit oldBusy = mBusy;
    int oldPend = mPend;
    int add = 0;
    if (mActive) begin
      if (mem_waitrequest_i) begin
        if (mStall != 32'hFFFF_FFFF) mStall = mStall + 32'd1;
      end else if (mIsRead) begin
        add = BL;
        mActive = 0;
      end else if (mBeat == BL - 1) begin
        mActive = 0;
      end else begin
        mBeat++;
      end
    end else if (trans_valid_i && modelReady(trans_type_i)) begin
      if (oldPend == 0 && !oldBusy) mStall = '0;
      mActive = 1; mIsRead = trans_type_i; mAddr = trans_addr_i;
      mSeed = pattern_i; mBeat = 0;
    end
    if (mem_readdatavalid_i) begin
      if (oldPend == 0) mUnexp = 1;
      else mPend--;
    end
    mPend += add;
    mBusy = mActive || (mPend != 0);
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) modelReset();
    else modelStep();
  end

  always @(negedge clk_i) begin
    if (checkEn) begin
      checkOutput("write",  mem_write_o, mActive && !mIsRead);
      checkOutput("read",   mem_read_o,  mActive && mIsRead);
      checkOutput("addr",   mem_address_o, mActive ? mAddr : '0);
      checkOutput("wdata",  mem_writedata_o, (mActive && !mIsRead) ? beatData(mSeed, mBeat) : '0);
      checkOutput("bcount", mem_burstcount_o, 8'(BL));
      checkOutput("ready",  trans_ready_o, modelReady(trans_type_i));
      checkOutput("busy",   trans_busy_o, mBusy);
      checkOutput("unexp",  rd_unexp_o, mUnexp);
`ifdef MEM_TRANS_STALL_CNT_EN
      checkOutput("stall",  stall_cnt_o, mStall);
`else
      checkOutput("stall",  stall_cnt_o, '0);
`endif
    end
  end

  task automatic applyStimulus(input bit v, input bit t, input logic [AW-1:0] a,
                               input logic [31:0] p, input bit wr, input bit rdv);
    @(posedge clk_i);
    #1;
    trans_valid_i       = v;
    trans_type_i        = t;
    trans_addr_i        = a;
    pattern_i           = p;
    mem_waitrequest_i   = wr;
    mem_readdatavalid_i = rdv;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((mActive || mPend > 0 || mBusy) && n < budget) begin
      @(posedge clk_i);
      #1;
      trans_valid_i       = 0;
      mem_waitrequest_i   = 0;
      mem_readdatavalid_i = (mPend > 0);
      n++;
    end
    checkOutput("drainTimeout", n < budget, 1'b1);
    applyStimulus(0, 0, '0, '0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    bit [6:0] wrSeq;
    rst_i = 1; trans_valid_i = 0; trans_type_i = 0; trans_addr_i = '0;
    pattern_i = '0; mem_waitrequest_i = 0; mem_readdatavalid_i = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 0;
    checkEn = 1;

    // Reset state
    @(negedge clk_i);
    checkOutput("rstBcount", mem_burstcount_o, 8'd4);
    checkOutput("rstWrite",  mem_write_o, 1'b0);
    checkOutput("rstBusy",   trans_busy_o, 1'b0);
    checkOutput("rstReady",  trans_ready_o, 1'b1);
    checkOutput("rstAddr",   mem_address_o, '0);

    // Plain write burst
    applyStimulus(1, 0, 'h10, 32'hA5A5_0000, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, '0, '0, 0, 0);
      @(negedge clk_i);
      checkOutput("litWrite", mem_write_o, 1'b1);
      checkOutput("litData",  mem_writedata_o, {4{32'hA5A5_0000}} ^ 128'(k));
      checkOutput("litAddr",  mem_address_o, 'h10);
    end
    applyStimulus(0, 0, '0, '0, 0, 0);
    @(negedge clk_i);
    checkOutput("litWrEnd", mem_write_o, 1'b0);
    checkOutput("litBusyLow", trans_busy_o, 1'b0);

    // Write stalled three cycles on beat 1
    wrSeq = 7'b0001110;
    cnt = 0;
    applyStimulus(1, 0, 'h20, 32'h1234_5678, 0, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, '0, '0, wrSeq[i], 0);
      @(negedge clk_i);
      if (mem_write_o) cnt++;
      if (i >= 1 && i <= 4)
        checkOutput("litStallData", mem_writedata_o, {4{32'h1234_5678}} ^ 128'd1);
    end
    applyStimulus(0, 0, '0, '0, 0, 0);
    @(negedge clk_i);
    checkOutput("litWrCycles", 32'(cnt), 32'd7);
`ifdef MEM_TRANS_STALL_CNT_EN
    checkOutput("litStallCnt", stall_cnt_o, 32'd3);
`endif

    // Back-to-back reads until the outstanding budget is full
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 1, 'h40, '0, 0, 0);
      @(negedge clk_i);
      if (mem_read_o) cnt++;
    end
    checkOutput("litReadCount", 32'(cnt), 32'd16);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 1, 'h40, '0, 0, 1);
      @(negedge clk_i);
      checkOutput("litBlocked", trans_ready_o, 1'b0);
    end
    applyStimulus(1, 1, 'h40, '0, 0, 0);
    @(negedge clk_i);
    checkOutput("litUnblocked", trans_ready_o, 1'b1);
    applyStimulus(0, 0, '0, '0, 0, 0);
    drain(300);

    // Read taken in the same cycle as a returning word with 5 pending
    applyStimulus(1, 1, 'h50, '0, 0, 0);
    applyStimulus(0, 0, '0, '0, 0, 0);
    applyStimulus(1, 1, 'h54, '0, 0, 0);
    applyStimulus(0, 0, '0, '0, 0, 0);
    applyStimulus(0, 0, '0, '0, 0, 1);
    applyStimulus(0, 0, '0, '0, 0, 1);
    applyStimulus(0, 0, '0, '0, 0, 1);
    applyStimulus(1, 1, 'h58, '0, 0, 0);
    applyStimulus(0, 0, '0, '0, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, '0, '0, 0, 1);
      @(negedge clk_i);
      checkOutput("litPendBusy", trans_busy_o, 1'b1);
    end
    applyStimulus(0, 0, '0, '0, 0, 0);
    @(negedge clk_i);
    checkOutput("litPendDone", trans_busy_o, 1'b0);
    checkOutput("litNoUnexp", rd_unexp_o, 1'b0);

    // Unexpected readdatavalid
    applyStimulus(0, 0, '0, '0, 0, 1);
    applyStimulus(0, 0, '0, '0, 0, 0);
    @(negedge clk_i);
    checkOutput("litUnexp", rd_unexp_o, 1'b1);
    repeat (5) applyStimulus(0, 0, '0, '0, 0, 0);
    @(negedge clk_i);
    checkOutput("litUnexpSticky", rd_unexp_o, 1'b1);
    checkOutput("litUnexpBusy", trans_busy_o, 1'b0);

    // Reset in the middle of beat 2
    applyStimulus(1, 0, 'h80, 32'hDEAD_BEEF, 0, 0);
    applyStimulus(0, 0, '0, '0, 0, 0);
    applyStimulus(0, 0, '0, '0, 0, 0);
    applyStimulus(0, 0, '0, '0, 0, 0);
    #2 rst_i = 1;
    #1;
    checkOutput("litRstWrite", mem_write_o, 1'b0);
    checkOutput("litRstBusy",  trans_busy_o, 1'b0);
    checkOutput("litRstData",  mem_writedata_o, '0);
    checkOutput("litRstUnexp", rd_unexp_o, 1'b0);
    @(posedge clk_i);
    #3 rst_i = 0;
    applyStimulus(1, 0, 'h90, 32'hCAFE_F00D, 0, 0);
    applyStimulus(0, 0, '0, '0, 0, 0);
    @(negedge clk_i);
    checkOutput("litRestartData", mem_writedata_o, {4{32'hCAFE_F00D}});
    checkOutput("litRestartAddr", mem_address_o, 'h90);
    drain(50);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_i);
      #1;
      trans_valid_i       = ($urandom_range(0, 2) == 0);
      trans_type_i        = 1'($urandom_range(0, 1));
      trans_addr_i        = AW'($urandom);
      pattern_i           = $urandom;
      mem_waitrequest_i   = ($urandom_range(0, 3) == 0);
      mem_readdatavalid_i = (mPend > 0) && ($urandom_range(0, 2) == 0);
    end
    drain(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
